// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - micro-program sequencer (uPC, branch/jump select, done pulse)
// Optional loop counter for cond_sel=3 is built only when UCSEQ_LOOP_EN is defined.
module ucode_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                LOOP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              z,
  input  logic [1:0]        cond_sel,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              end_flag,
  input  logic              loop_load,
  input  logic [LOOP_W-1:0] loop_val,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done,
  output logic              loop_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] upc_nxt;
  logic              take;
  logic              jump_ok;
  logic              exec;

  // A microinstruction "executes" only on an unstalled, non-final RUN cycle.
  assign exec = (state == RUN) && !stall && !end_flag;

`ifdef UCSEQ_LOOP_EN
  logic [LOOP_W-1:0] loop_cnt;

  assign jump_ok   = (loop_cnt != '0);
  assign loop_zero = (loop_cnt == '0);

  // A load takes priority over the decrement; the branch still sees the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_cnt <= '0;
    end else if (loop_load) begin
      loop_cnt <= loop_val;
    end else if (exec && (cond_sel == 2'd3) && jump_ok) begin
      loop_cnt <= loop_cnt - 1'b1;
    end
  end
`else
  logic unused_loop;

  assign unused_loop = ^{loop_load, loop_val};
  assign jump_ok     = 1'b1;
  assign loop_zero   = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          upc_nxt   = START_ADDR;
        end
      end
      RUN: begin
        if (!stall) begin
          if (end_flag) begin
            state_nxt = DONE;
          end else begin
            take = ((cond_sel == 2'd1) &&  z) ||
                   ((cond_sel == 2'd2) && !z) ||
                   ((cond_sel == 2'd3) && jump_ok);
            upc_nxt = take ? branch_addr : upc + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      upc   <= '0;
    end else begin
      state <= state_nxt;
      upc   <= upc_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Microprogram sequencer for the matrix-multiplication core's control unit. Holds the micro-program counter (uPC) that addresses the control store and starts a micro-routine on request. Each cycle it chooses the next uPC from the current microinstruction's condition-select field and the datapath zero flag: increment, conditional branch on z or ~z, or jump/loop. It signals completion to the core scheduler with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 8, uPC / control-store address width
- START_ADDR, 0, uPC loaded when a routine starts
- LOOP_W, 8, loop counter width (used only with UCSEQ_LOOP_EN)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin routine; sampled only in IDLE
- stall  in  1  datapath wait; freezes uPC and state in RUN
- z  in  1  datapath zero flag, valid in the cycle it is used
- cond_sel  in  2  microinstruction field: 0 = next, 1 = branch if z, 2 = branch if ~z, 3 = jump/loop
- branch_addr  in  ADDR_W  microinstruction branch target
- end_flag  in  1  microinstruction marks last of routine
- loop_load  in  1  load loop counter
- loop_val  in  LOOP_W  loop count
- upc  out  ADDR_W  control-store address
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- loop_zero  out  1  loop counter == 0

## Operation
- The control store is asynchronous-read. cond_sel, branch_addr and end_flag belong to the word at the current upc and are valid in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE: upc holds. On start=1, upc <= START_ADDR and the FSM goes to RUN.
- RUN, stall=1: upc, FSM state and loop counter hold. end_flag is ignored.
- RUN, stall=0, end_flag=1: go to DONE. upc holds; the branch decision is not applied.
- RUN, stall=0, end_flag=0: take = (cond_sel==1 & z) | (cond_sel==2 & ~z) | (cond_sel==3 & jump_ok).
  - upc <= take ? branch_addr : upc+1.
  - Increment wraps modulo 2^ADDR_W (all-ones -> 0).
- DONE: done=1 for exactly this cycle, then IDLE. start in DONE is ignored.
- start while busy is ignored; the routine is never restarted.
- Outputs are registered: busy = (state==RUN), done = (state==DONE).
- Reset mid-routine: immediate return to IDLE with all reset values; no done pulse.

## Timing
- Reset values: upc=0, busy=0, done=0, state IDLE, loop counter=0, loop_zero=1.
- Start latency:
  - start high before edge N: upc=START_ADDR and busy=1 after edge N.
  - First microinstruction executes in cycle N+1.
- Each non-stalled RUN cycle advances upc by exactly one step; branches have no penalty cycle.
- end_flag seen (unstalled) before edge M: busy=0 and done=1 after M; IDLE after M+1.
- The earliest restart is start sampled at edge M+2.
- A routine of K microinstructions with S stall cycles keeps busy high for K+S cycles.

## Configuration
Macro: UCSEQ_LOOP_EN.

With UCSEQ_LOOP_EN defined:
- The LOOP_W counter is instantiated; loop_zero = (counter==0).
- Loading: loop_load=1 loads loop_val on any edge, in any state.
- cond_sel=3 means "loop": jump_ok = (counter!=0). On an unstalled RUN cycle with jump_ok, the counter decrements; at 0 it falls through to upc+1.
- loop_load together with a cond 3 decision: the branch uses the old counter value, and the load wins over the decrement.

Without the macro:
- No counter is built; cond_sel=3 is an unconditional jump (jump_ok=1).
- loop_load and loop_val are ignored; loop_zero is tied to 1.

## Test plan
- Reset/idle: assert rst_n=0 mid-RUN at upc=5 -> upc=0, busy=0, done=0 immediately; no done pulse; start ignored while rst_n=0.
- Straight-line: START_ADDR=0, words 0..3 cond 0, word 3 end_flag -> upc 0,1,2,3; busy 4 cycles; done one cycle; then IDLE.
- Branches: word 2 cond 1 to 10 with z=1 -> upc=10; repeat with z=0 -> upc=3. Word 2 cond 2 with z=0 -> upc=10.
- Stall and wrap: upc=255 (ADDR_W=8) with stall=1 for 3 cycles -> holds 255; then cond 0 -> upc=0. start during RUN -> no effect.
- Loop (UCSEQ_LOOP_EN): loop_val=3, loop_load, word 4 cond 3 to 4 -> word 4 runs 4 times, loop_zero rises, then upc=5. Same with loop_load coinciding with the 3rd visit -> counter reloads to loop_val.
- No macro: cond 3 at word 4 to 20 -> upc=20 regardless of loop_load; loop_zero=1.
